sigma_sched: RTL and testbench
==============================

SIGMA_SCHED -- requirements
Module: sigma_sched

Interface
REQ-001 Parameter: N, default `N (from config.svh), total word width, signed-magnitude (MSB = sign).
REQ-002 Parameter: F, default `F, fraction bits; carried only, no rescaling in this block.
REQ-003 Parameter: TILES, default 4, 32-input tiles summed per neuron; legal range 1..16.
REQ-004 Parameter: NEURONS, default 8, neurons per layer pass; legal range 1..256.
REQ-005 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-007 Port: start  input  1  one-cycle request to begin a layer pass.
REQ-008 Port: clear  input  1  synchronous abort, returns the block to IDLE.
REQ-009 Port: rd_en  output  1  read strobe to product memory feeding the 32-input sigma tree.
REQ-010 Port: neuron_idx  output  $clog2(NEURONS) (min 1)  neuron currently addressed.
REQ-011 Port: tile_idx  output  $clog2(TILES) (min 1)  tile currently addressed.
REQ-012 Port: sigma_in  input  N  sigma-tree sum for the addressed tile; valid exactly 1 cycle after rd_en.
REQ-013 Port: acc_out  output  N  completed neuron sum, signed-magnitude.
REQ-014 Port: out_valid  output  1  acc_out valid; held until accepted.
REQ-015 Port: out_ready  input  1  downstream accepts acc_out when out_valid && out_ready.
REQ-016 Port: busy  output  1  high in every state except IDLE.
REQ-017 Port: done  output  1  one-cycle pulse after the last neuron is accepted.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, ACC, OUT, FIN.
REQ-019 IDLE: start=1 -> FETCH, neuron_idx=0, tile_idx=0, accumulator=+0; otherwise stay.
REQ-020 FETCH: rd_en=1 for exactly this one cycle; next state ACC.
REQ-021 ACC: accumulator <= acc + sigma_in (signed-magnitude add); if tile_idx<TILES-1 then tile_idx++ -> FETCH, else -> OUT with the final sum latched into acc_out.
REQ-022 OUT: out_valid=1, acc_out stable; on out_ready: if neuron_idx<NEURONS-1 then neuron_idx++, tile_idx=0, acc=+0 -> FETCH, else -> FIN.
REQ-023 FIN: done=1 for one cycle -> IDLE; neuron_idx and tile_idx return to 0.
REQ-024 Latency with out_ready held high: 2*TILES+1 cycles per neuron from first rd_en to out_valid handshake; done asserted 1 cycle after the last handshake.
REQ-025 Addition: equal signs -> magnitudes add, sign kept; different signs -> larger magnitude minus smaller, sign of larger; equal magnitudes -> +0.
REQ-026 Magnitude overflow SHALL saturate to all-ones magnitude (N-1 bits) with the operand sign; no wrap-around.
REQ-027 Negative zero (sign=1, magnitude=0) on sigma_in SHALL be treated as +0; acc_out never presents negative zero.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 clear=1 in any state -> IDLE next cycle, all outputs to reset values; clear has priority over start and out_ready.
REQ-030 rd_en SHALL never assert outside FETCH; out_valid never outside OUT.
REQ-031 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, rd_en=0, out_valid=0, done=0, busy=0, acc_out=0, neuron_idx=0, tile_idx=0, accumulator=+0.
REQ-033 Reset deasserting mid-pass SHALL leave the block in IDLE awaiting a fresh start; no partial result is emitted.

Verification
REQ-034 TILES=4, NEURONS=1, sigma_in=+1.0 each tile, out_ready=1 -> acc_out=+4.0, out_valid at cycle 9 after start, done the next cycle.
REQ-035 Mixed signs: tiles +3.0, -5.0, +2.0, 0 -> acc_out=+0 (sign bit 0); tiles -1.0, -2.0, sign-magnitude negative zero, +0.5 -> -2.5.
REQ-036 Saturation: two tiles of max positive magnitude -> acc_out = max positive; same with negative -> max negative.
REQ-037 Backpressure: out_ready low 5 cycles in OUT -> out_valid and acc_out stable throughout, no rd_en, advance only on handshake.
REQ-038 start pulsed during ACC -> ignored; clear asserted in ACC of neuron 2 -> IDLE next cycle, no out_valid, no done.
REQ-039 rst_n low asynchronously in FETCH -> all outputs at reset values before the next clock edge; subsequent start runs a full pass from neuron 0.

Source files
------------

// File: rtl/sigma_sched.sv
// Sequences product-memory reads tile by tile, accumulates sigma-tree sums per neuron in
// signed-magnitude with saturation, and hands each neuron result downstream via valid/ready.
module sigma_sched #(
  parameter int unsigned N       = 16,
  parameter int unsigned F       = 8,
  parameter int unsigned TILES   = 4,
  parameter int unsigned NEURONS = 8,
  localparam int unsigned NW = (NEURONS > 1) ? $clog2(NEURONS) : 1,
  localparam int unsigned TW = (TILES > 1) ? $clog2(TILES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clear,
  output logic          rd_en,
  output logic [NW-1:0] neuron_idx,
  output logic [TW-1:0] tile_idx,
  input  logic [N-1:0]  sigma_in,
  output logic [N-1:0]  acc_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  if (TILES < 1 || TILES > 16) begin : g_bad_tiles
    $error("TILES must be in 1..16");
  end
  if (NEURONS < 1 || NEURONS > 256) begin : g_bad_neurons
    $error("NEURONS must be in 1..256");
  end
  if (F >= N) begin : g_bad_frac
    $error("F must be smaller than N");
  end

  typedef enum logic [2:0] {StIdle, StFetch, StAcc, StOut, StFin} state_e;

  state_e        state_q, state_d;
  logic [NW-1:0] neuron_q, neuron_d;
  logic [TW-1:0] tile_q, tile_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  acc_out_q, acc_out_d;
  logic          rd_en_q, rd_en_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  sum;

  // Signed-magnitude add; -0 on either input behaves as +0, result is never -0.
  function automatic logic [N-1:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic          sa, sb, s;
    logic [N-2:0]  ma, mb, m;
    logic [N-1:0]  wide;
    sa   = a[N-1];
    ma   = a[N-2:0];
    mb   = b[N-2:0];
    sb   = b[N-1] & (mb != '0);
    wide = '0;
    if (sa == sb) begin
      wide = {1'b0, ma} + {1'b0, mb};
      s    = sa;
      m    = wide[N-1] ? '1 : wide[N-2:0];
    end else if (ma >= mb) begin
      s = sa;
      m = ma - mb;
    end else begin
      s = sb;
      m = mb - ma;
    end
    if (m == '0) s = 1'b0;
    return {s, m};
  endfunction

  always_comb begin
    state_d   = state_q;
    neuron_d  = neuron_q;
    tile_d    = tile_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    sum       = sm_add(acc_q, sigma_in);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StFetch;
          neuron_d = '0;
          tile_d   = '0;
          acc_d    = '0;
        end
      end
      StFetch: state_d = StAcc;
      StAcc: begin
        acc_d = sum;
        if (tile_q != TW'(TILES - 1)) begin
          tile_d  = tile_q + TW'(1);
          state_d = StFetch;
        end else begin
          acc_out_d = sum;
          state_d   = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          if (neuron_q != NW'(NEURONS - 1)) begin
            neuron_d = neuron_q + NW'(1);
            tile_d   = '0;
            acc_d    = '0;
            state_d  = StFetch;
          end else begin
            state_d = StFin;
          end
        end
      end
      StFin: begin
        state_d  = StIdle;
        neuron_d = '0;
        tile_d   = '0;
      end
      default: state_d = StIdle;
    endcase

    if (clear) begin
      state_d   = StIdle;
      neuron_d  = '0;
      tile_d    = '0;
      acc_d     = '0;
      acc_out_d = '0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    rd_en_d     = (state_d == StFetch);
    out_valid_d = (state_d == StOut);
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StFin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      neuron_q    <= '0;
      tile_q      <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      neuron_q    <= neuron_d;
      tile_q      <= tile_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      rd_en_q     <= rd_en_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign neuron_idx = neuron_q;
  assign tile_idx   = tile_q;
  assign acc_out    = acc_out_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sigma_sched.sv
// Randomized scoreboard bench for sigma_sched: integer reference model with clamping,
// decoupled monitor that checks every output handshake against a queue of expected sums.
module tb_sigma_sched;

  localparam int N       = 16;
  localparam int F       = 8;
  localparam int TILES   = 4;
  localparam int NEURONS = 3;
  localparam int MAXMAG  = (1 << (N - 1)) - 1;

  logic         clk = 1'b0;
  logic         rst_n, start, clear, out_ready;
  logic         rd_en, out_valid, busy, done;
  logic [1:0]   neuron_idx, tile_idx;
  logic [N-1:0] sigma_in, acc_out;

  sigma_sched #(.N(N), .F(F), .TILES(TILES), .NEURONS(NEURONS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear      (clear),
    .rd_en      (rd_en),
    .neuron_idx (neuron_idx),
    .tile_idx   (tile_idx),
    .sigma_in   (sigma_in),
    .acc_out    (acc_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int done_cnt = 0;
  int first_valid_cyc = -1;
  int last_hs_cyc = -1;
  int done_cyc = -1;
  int start_cyc = 0;
  int rdy_mode = 0;
  logic [N-1:0] mem [NEURONS][TILES];
  logic [N-1:0] exp_q [$];

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
  endtask

  function automatic int sm2int(input logic [N-1:0] v);
    int m;
    m = int'(v[N-2:0]);
    return v[N-1] ? -m : m;
  endfunction

  function automatic logic [N-1:0] int2sm(input int x);
    logic [N-2:0] m;
    if (x < 0) begin
      m = (N-1)'(-x);
      return {1'b1, m};
    end
    m = (N-1)'(x);
    return {1'b0, m};
  endfunction

  // Reference: running integer sum clamped to the representable magnitude after every tile.
  function automatic logic [N-1:0] ref_sum(input int n);
    int acc;
    acc = 0;
    for (int t = 0; t < TILES; t++) begin
      acc += sm2int(mem[n][t]);
      if (acc > MAXMAG) acc = MAXMAG;
      if (acc < -MAXMAG) acc = -MAXMAG;
    end
    return int2sm(acc);
  endfunction

  function automatic logic [N-1:0] rand_word();
    logic [N-1:0] w;
    case ($urandom_range(0, 3))
      0: w = {1'($urandom), (N-1)'($urandom_range(0, 16'h1ff))};
      1: w = {1'($urandom), (N-1)'($urandom_range(16'h7000, MAXMAG))};
      2: w = {1'($urandom), {(N-1){1'b0}}};
      default: w = N'($urandom);
    endcase
    return w;
  endfunction

  task automatic fill_random();
    for (int n = 0; n < NEURONS; n++)
      for (int t = 0; t < TILES; t++) mem[n][t] = rand_word();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Product memory: data appears only in the cycle after rd_en, garbage otherwise.
  initial begin
    logic       pend;
    logic [1:0] pn, pt;
    sigma_in = '0;
    forever begin
      @(negedge clk);
      pend = rd_en;
      pn   = neuron_idx;
      pt   = tile_idx;
      @(posedge clk);
      #1;
      sigma_in = pend ? mem[pn][pt] : N'($urandom);
    end
  end

  initial begin
    int vcnt;
    vcnt = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      vcnt = out_valid ? vcnt + 1 : 0;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (vcnt > 5);
      endcase
    end
  end

  initial begin
    logic         prev_valid, prev_hs;
    logic [N-1:0] prev_acc, e;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    prev_acc   = '0;
    forever begin
      @(negedge clk);
      if (out_valid) check("no_rd_en_in_out", int'(rd_en), 0);
      if (out_valid && prev_valid && !prev_hs) check("acc_out_stable", int'(acc_out), int'(prev_acc));
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got acc_out=%0h, expected no output", acc_out);
        end else begin
          e = exp_q.pop_front();
          check("acc_out", int'(acc_out), int'(e));
        end
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      prev_acc   = acc_out;
    end
  end

  task automatic issue_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    start_cyc = cyc;
    first_valid_cyc = -1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0, t;
    d0 = done_cnt;
    t  = 0;
    while (done_cnt == d0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      checks++;
      $display("FAIL %s_timeout: got no done, expected done within 2000 cycles", name);
    end else begin
      repeat (3) @(posedge clk);
      check({name, "_done_pulses"}, done_cnt - d0, 1);
      check({name, "_queue_drained"}, exp_q.size(), 0);
    end
  endtask

  // Waits (bounded) until the DUT sits in ACC of the given neuron.
  task automatic wait_acc(input int n, output bit ok);
    int t;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 500) begin
      @(posedge clk);
      #1;
      ok = busy && !rd_en && !out_valid && !done && (int'(neuron_idx) == n);
      t++;
    end
    if (!ok) begin
      checks++;
      $display("FAIL wait_acc_timeout: got no ACC state, expected neuron %0d in ACC", n);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_rd_en"}, int'(rd_en), 0);
    check({name, "_out_valid"}, int'(out_valid), 0);
    check({name, "_done"}, int'(done), 0);
    check({name, "_acc_out"}, int'(acc_out), 0);
    check({name, "_neuron_idx"}, int'(neuron_idx), 0);
    check({name, "_tile_idx"}, int'(tile_idx), 0);
  endtask

  initial begin
    bit ok;
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // +1.0 per tile: +4.0 per neuron, OUT nine cycles after start, done one after last handshake.
    for (int n = 0; n < NEURONS; n++)
      for (int t = 0; t < TILES; t++) mem[n][t] = 16'h0100;
    rdy_mode = 0;
    for (int n = 0; n < NEURONS; n++) exp_q.push_back(16'h0400);
    issue_start();
    wait_done("ones");
    check("first_valid_latency", first_valid_cyc - start_cyc, 9);
    check("done_after_last_hs", done_cyc - last_hs_cyc, 1);

    // Mixed signs, negative-zero input, saturation; backpressure; start during ACC ignored.
    mem[0] = '{16'h0300, 16'h8500, 16'h0200, 16'h0000};
    mem[1] = '{16'h8100, 16'h8200, 16'h8000, 16'h0080};
    mem[2] = '{16'h7fff, 16'h7fff, 16'h0000, 16'h0000};
    rdy_mode = 2;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h8280);
    exp_q.push_back(16'h7fff);
    issue_start();
    wait_acc(0, ok);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("mixed");

    // Negative saturation, saturate-then-subtract, all negative zeros.
    mem[0] = '{16'hffff, 16'hffff, 16'h0000, 16'h0000};
    mem[1] = '{16'h7fff, 16'h7fff, 16'h8001, 16'h0000};
    mem[2] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    rdy_mode = 1;
    exp_q.push_back(16'hffff);
    exp_q.push_back(16'h7ffe);
    exp_q.push_back(16'h0000);
    issue_start();
    wait_done("neg_sat");

    // Clear in ACC of neuron 2: neurons 0 and 1 emitted, nothing else, no done.
    fill_random();
    rdy_mode = 0;
    exp_q.push_back(ref_sum(0));
    exp_q.push_back(ref_sum(1));
    issue_start();
    wait_acc(2, ok);
    d0 = done_cnt;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check_reset_outputs("clear");
    repeat (20) @(posedge clk);
    check("clear_no_done", done_cnt - d0, 0);
    check("clear_queue_drained", exp_q.size(), 0);

    // Asynchronous reset in FETCH, then a fresh full pass.
    fill_random();
    issue_start();
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(posedge clk);
      #1;
      ok = rd_en;
    end
    check("reached_fetch", int'(ok), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_after_reset", int'(busy), 0);
    for (int n = 0; n < NEURONS; n++) exp_q.push_back(ref_sum(n));
    issue_start();
    wait_done("post_reset");

    for (int p = 0; p < 6; p++) begin
      fill_random();
      rdy_mode = p % 3;
      for (int n = 0; n < NEURONS; n++) exp_q.push_back(ref_sum(n));
      issue_start();
      wait_done("random");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
